// File: rtl/display_unit.sv
// display_unit
//   Latches a 14-bit value from the register file on the load strobe. In
//   binary mode the value is shown on 14 LEDs. In hex mode it is shown on a
//   4-digit multiplexed seven-segment display. The prescaler and digit scan
//   run freely and are never restarted by a load.
//
// Ports
//   clk            system clock, rising-edge active
//   rst            asynchronous, active-high reset
//   ldA            load strobe, level-sensitive (latches on every high edge)
//   displaySelect  0 = binary on LEDs, 1 = hex on seven-segment
//   dataIn[13:0]   value to display
//   led[13:0]      binary display, registered
//   seg[6:0]       segments {g,f,e,d,c,b,a}, active-low, registered
//   an[3:0]        digit enables, active-low, an[0] = rightmost, registered
//   loaded         high once any value has been latched since reset
module display_unit #(
  parameter int unsigned REFRESH_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ldA,
  input  logic        displaySelect,
  input  logic [13:0] dataIn,
  output logic [13:0] led,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        loaded
);

  localparam logic [15:0] PRESC_LAST = 16'(REFRESH_DIV - 1);
  localparam logic [6:0]  SEG_BLANK  = 7'b1111111;
  localparam logic [3:0]  AN_OFF     = 4'b1111;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  logic [13:0] value_q, value_d;
  logic        mode_q, mode_d;
  logic        loaded_q, loaded_d;
  logic [15:0] presc_q, presc_d;
  logic [1:0]  idx_q, idx_d;
  logic [13:0] led_q, led_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic [3:0]  nibble;
  logic        tick;

  always_comb begin
    value_d  = value_q;
    mode_d   = mode_q;
    loaded_d = loaded_q;
    if (ldA) begin
      value_d  = dataIn;
      mode_d   = displaySelect;
      loaded_d = 1'b1;
    end

    // Free-running scan: a load never touches prescaler or digit index.
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
    idx_d   = tick ? idx_q + 2'd1 : idx_q;

    case (idx_q)
      2'd0:    nibble = value_q[3:0];
      2'd1:    nibble = value_q[7:4];
      2'd2:    nibble = value_q[11:8];
      default: nibble = {2'b00, value_q[13:12]};
    endcase

    // All outputs derive from the same latched mode, so a mode change
    // switches led/seg/an together on one edge.
    led_d = mode_q ? 14'd0 : value_q;
    if (mode_q && loaded_q) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = hex_glyph(nibble);
    end else begin
      an_d  = AN_OFF;
      seg_d = SEG_BLANK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q  <= '0;
      mode_q   <= 1'b0;
      loaded_q <= 1'b0;
      presc_q  <= '0;
      idx_q    <= '0;
      led_q    <= '0;
      seg_q    <= SEG_BLANK;
      an_q     <= AN_OFF;
    end else begin
      value_q  <= value_d;
      mode_q   <= mode_d;
      loaded_q <= loaded_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      led_q    <= led_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign led    = led_q;
  assign seg    = seg_q;
  assign an     = an_q;
  assign loaded = loaded_q;

endmodule

// File: tb/tb_display_unit.sv
module tb_display_unit;
  localparam int DIV = 4;

  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic        clk = 1'b0;
  logic        rst;
  logic        ldA;
  logic        displaySelect;
  logic [13:0] dataIn;
  logic [13:0] led;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        loaded;

  display_unit #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .ldA(ldA), .displaySelect(displaySelect),
    .dataIn(dataIn), .led(led), .seg(seg), .an(an), .loaded(loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [13:0] led;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        loaded;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  logic [13:0] m_val;
  logic        m_mode;
  logic        m_loaded;
  int          m_pre;
  int          m_idx;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_val = '0; m_mode = 1'b0; m_loaded = 1'b0; m_pre = 0; m_idx = 0;
  endtask

  // Drive one cycle of stimulus, predict the outputs after the coming edge,
  // then compare against the DUT once that edge has passed.
  task automatic step(input logic ld, input logic sel, input logic [13:0] din);
    exp_t e;
    exp_t got;
    logic [3:0] nib;
    ldA = ld; displaySelect = sel; dataIn = din;
    e.led = m_mode ? 14'd0 : m_val;
    if (m_mode && m_loaded) begin
      nib  = 4'((m_val >> (4 * m_idx)) & 14'hF);
      e.an  = 4'b1111 & ~(4'b0001 << m_idx);
      e.seg = GLYPH[nib];
    end else begin
      e.an  = 4'b1111;
      e.seg = 7'b1111111;
    end
    if (ld) begin
      m_val = din; m_mode = sel; m_loaded = 1'b1;
    end
    if (m_pre == DIV - 1) begin
      m_pre = 0; m_idx = (m_idx + 1) % 4;
    end else begin
      m_pre++;
    end
    e.loaded = m_loaded;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    got.led = led; got.seg = seg; got.an = an; got.loaded = loaded;
    e = sbq.pop_front();
    chk("sb_led", 16'(got.led), 16'(e.led));
    chk("sb_seg", 16'(got.seg), 16'(e.seg));
    chk("sb_an", 16'(got.an), 16'(e.an));
    chk("sb_loaded", 16'(got.loaded), 16'(e.loaded));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_led"}, 16'(led), 16'h0);
    chk({tag, "_seg"}, 16'(seg), 16'h7F);
    chk({tag, "_an"}, 16'(an), 16'hF);
    chk({tag, "_loaded"}, 16'(loaded), 16'h0);
  endtask

  initial begin
    int cnt [4];
    logic [3:0] an_start;
    bit found;

    rst = 1'b1; ldA = 1'b0; displaySelect = 1'b0; dataIn = '0;
    model_reset();
    #2;
    chk_reset_outputs("reset_noclk");
    @(posedge clk);
    #1;
    rst = 1'b0;

    repeat (3) step(1'b0, 1'b0, 14'h0);

    // Binary load held for three cycles.
    step(1'b1, 1'b0, 14'h2A5C);
    chk("bin_loaded_first_edge", 16'(loaded), 16'h1);
    step(1'b1, 1'b0, 14'h2A5C);
    chk("bin_led_latency", 16'(led), 16'h2A5C);
    step(1'b1, 1'b0, 14'h2A5C);
    step(1'b0, 1'b0, 14'h0);
    chk("bin_an_off", 16'(an), 16'hF);

    // Hex scan over one full 16-cycle period.
    step(1'b1, 1'b1, 14'h3A5C);
    step(1'b0, 1'b1, 14'h0);
    cnt = '{0, 0, 0, 0};
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 14'h0);
      chk("hex_led_zero", 16'(led), 16'h0);
      case (an)
        4'b1110: begin cnt[0]++; chk("hex_d0_C", 16'(seg), 16'(7'b1000110)); end
        4'b1101: begin cnt[1]++; chk("hex_d1_5", 16'(seg), 16'(7'b0010010)); end
        4'b1011: begin cnt[2]++; chk("hex_d2_A", 16'(seg), 16'(7'b0001000)); end
        4'b0111: begin cnt[3]++; chk("hex_d3_3", 16'(seg), 16'(7'b0110000)); end
        default: chk("hex_an_onehot", 16'(an), 16'hE);
      endcase
    end
    for (int d = 0; d < 4; d++) chk("hex_digit_slots", 16'(cnt[d]), 16'd4);

    // Hex to binary mode switch with the same value.
    step(1'b1, 1'b1, 14'h0001);
    step(1'b0, 1'b1, 14'h0);
    step(1'b1, 1'b0, 14'h0001);
    step(1'b0, 1'b0, 14'h0);
    chk("switch_an", 16'(an), 16'hF);
    chk("switch_seg", 16'(seg), 16'h7F);
    chk("switch_led", 16'(led), 16'h0001);

    // All-ones value: top digit holds only two bits.
    step(1'b1, 1'b1, 14'h3FFF);
    step(1'b0, 1'b1, 14'h0);
    an_start = an;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 14'h0);
      if (an == 4'b0111) chk("wrap_d3_3", 16'(seg), 16'(7'b0110000));
      else               chk("wrap_dx_F", 16'(seg), 16'(7'b0001110));
    end
    chk("wrap_period", 16'(an), 16'(an_start));

    // Reset during digit 2 of a hex display.
    step(1'b1, 1'b1, 14'h3A5C);
    found = 1'b0;
    for (int i = 0; i < 32 && !found; i++) begin
      step(1'b0, 1'b1, 14'h0);
      if (an == 4'b1011) found = 1'b1;
    end
    chk("find_digit2", 16'(found), 16'h1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("reset_midscan");
    model_reset();
    sbq.delete();
    @(posedge clk);
    #1;
    chk_reset_outputs("reset_held");
    rst = 1'b0;
    repeat (8) step(1'b0, 1'b1, 14'h0);
    chk("post_reset_blank", 16'(an), 16'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
